// File: rtl/br_resolve_ctrl_if.sv
// Signal bundle between the branch-resolution controller and dispatch,
// the two branch FUs, the checkpoint stack and fetch.
`ifndef STACK_NUM
`define STACK_NUM 4
`endif

interface br_resolve_ctrl_if #(
    parameter int STACK_NUM = `STACK_NUM,
    parameter int IDX_W     = $clog2(STACK_NUM)
);
    logic                 br_dispatch_valid;
    logic                 br_dispatch_stall;
    logic                 snapshot_enable;
    logic [IDX_W-1:0]     space_address;
    logic                 res_valid_0, res_valid_1;
    logic [STACK_NUM-1:0] res_mask_0, res_mask_1;
    logic                 res_mispredict_0, res_mispredict_1;
    logic [63:0]          res_target_0, res_target_1;
    logic                 recovery_request;
    logic                 br_correct;
    logic [STACK_NUM-1:0] recovery_mask;
    logic                 redirect_valid;
    logic [63:0]          redirect_pc;
    logic [STACK_NUM-1:0] squash_mask;

    modport master (
        input  br_dispatch_valid, res_valid_0, res_valid_1, res_mask_0, res_mask_1,
               res_mispredict_0, res_mispredict_1, res_target_0, res_target_1,
        output br_dispatch_stall, snapshot_enable, space_address, recovery_request,
               br_correct, recovery_mask, redirect_valid, redirect_pc, squash_mask
    );

    modport slave (
        output br_dispatch_valid, res_valid_0, res_valid_1, res_mask_0, res_mask_1,
               res_mispredict_0, res_mispredict_1, res_target_0, res_target_1,
        input  br_dispatch_stall, snapshot_enable, space_address, recovery_request,
               br_correct, recovery_mask, redirect_valid, redirect_pc, squash_mask
    );
endinterface

// File: rtl/br_resolve_ctrl.sv
// Branch-resolution controller: allocates checkpoint slots, turns FU resolutions
// into one recovery/correct command per cycle and keeps a shadow busy mask.
`ifndef STACK_NUM
`define STACK_NUM 4
`endif

module br_resolve_ctrl #(
    parameter int STACK_NUM = `STACK_NUM,
    parameter int IDX_W     = $clog2(STACK_NUM)
) (
    input logic              clock,
    input logic              reset,
    br_resolve_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(STACK_NUM + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

    state_t               state, state_nxt;
    logic [STACK_NUM-1:0] busy, busy_nxt;
    logic [IDX_W-1:0]     fifo [STACK_NUM];
    logic [IDX_W-1:0]     fifo_nxt [STACK_NUM];
    logic [IDX_W-1:0]     fifo_tmp [STACK_NUM];
    logic [CNT_W-1:0]     cnt, cnt_nxt, k;
    logic                 pend_valid;
    logic [IDX_W-1:0]     pend_idx;
    logic [63:0]          pend_pc;

    logic                 rec_q, cor_q, redir_q;
    logic [STACK_NUM-1:0] mask_q, squash_q;
    logic [63:0]          pc_q;

    logic [IDX_W-1:0]     low, alloc_idx, idx0, idx1, win_idx, p_idx, head;
    logic [63:0]          win_pc, p_pc;
    logic                 stall, snap, ok0, ok1, mp0, mp1, win_v, push0, push1;
    logic                 p_v, rec_go, pop;

    function automatic logic [IDX_W-1:0] enc(input logic [STACK_NUM-1:0] m);
        enc = '0;
        for (int i = 0; i < STACK_NUM; i++)
            if (m[i]) enc = IDX_W'(i);
    endfunction

    function automatic logic [STACK_NUM-1:0] le_mask(input logic [IDX_W-1:0] a);
        for (int i = 0; i < STACK_NUM; i++)
            le_mask[i] = (i <= int'(a));
    endfunction

    // Allocation: one slot below the lowest busy slot, top slot when empty.
    always_comb begin
        low = '0;
        for (int i = STACK_NUM - 1; i >= 0; i--)
            if (busy[i]) low = IDX_W'(i);
        alloc_idx = (busy == '0) ? IDX_W'(STACK_NUM - 1) : low - IDX_W'(1);
    end

    assign stall = busy[0] | rec_q | (state == FLUSH);
    assign snap  = bus.br_dispatch_valid & ~stall & ~reset;

    assign bus.br_dispatch_stall = stall;
    assign bus.snapshot_enable   = snap;
    assign bus.space_address     = snap ? alloc_idx : '0;
    assign bus.recovery_request  = rec_q;
    assign bus.br_correct        = cor_q;
    assign bus.recovery_mask     = mask_q;
    assign bus.redirect_valid    = redir_q;
    assign bus.redirect_pc       = pc_q;
    assign bus.squash_mask       = squash_q;

    always_comb begin
        idx0 = enc(bus.res_mask_0);
        idx1 = enc(bus.res_mask_1);
        // Slots already squashed have busy==0, so only the pending cutoff is explicit.
        ok0  = bus.res_valid_0 && busy[idx0] && !(pend_valid && idx0 <= pend_idx);
        ok1  = bus.res_valid_1 && busy[idx1] && !(pend_valid && idx1 <= pend_idx);
        mp0  = ok0 & bus.res_mispredict_0;
        mp1  = ok1 & bus.res_mispredict_1;
        win_v = mp0 | mp1;
        if (mp0 && (!mp1 || idx0 > idx1)) begin
            win_idx = idx0;
            win_pc  = bus.res_target_0;
        end else begin
            win_idx = idx1;
            win_pc  = bus.res_target_1;
        end
        push0 = ok0 && !bus.res_mispredict_0 && (!win_v || idx0 > win_idx);
        push1 = ok1 && !bus.res_mispredict_1 && (!win_v || idx1 > win_idx);
        p_v    = pend_valid | win_v;
        p_idx  = win_v ? win_idx : pend_idx;
        p_pc   = win_v ? win_pc : pend_pc;
        rec_go = p_v && (state != ISSUE);

        fifo_nxt = fifo;
        cnt_nxt  = cnt;
        if (push0 && cnt_nxt < CNT_W'(STACK_NUM)) begin
            fifo_nxt[cnt_nxt[IDX_W-1:0]] = idx0;
            cnt_nxt = cnt_nxt + CNT_W'(1);
        end
        if (push1 && cnt_nxt < CNT_W'(STACK_NUM)) begin
            fifo_nxt[cnt_nxt[IDX_W-1:0]] = idx1;
            cnt_nxt = cnt_nxt + CNT_W'(1);
        end

        fifo_tmp = fifo_nxt;
        k = '0;
        if (rec_go) begin
            for (int i = 0; i < STACK_NUM; i++)
                if (CNT_W'(i) < cnt_nxt && fifo_tmp[i] > p_idx) begin
                    fifo_nxt[k[IDX_W-1:0]] = fifo_tmp[i];
                    k = k + CNT_W'(1);
                end
            cnt_nxt = k;
        end

        // Corrects wait while any recovery is pending so a squashed slot is never retired.
        pop  = !p_v && (cnt_nxt != '0);
        head = fifo_nxt[0];
        if (pop) begin
            for (int i = 0; i < STACK_NUM - 1; i++)
                fifo_nxt[i] = fifo_nxt[i + 1];
            cnt_nxt = cnt_nxt - CNT_W'(1);
        end

        busy_nxt = busy | (snap ? (STACK_NUM'(1) << alloc_idx) : '0);
        if (pop)    busy_nxt = busy_nxt & ~(STACK_NUM'(1) << head);
        if (rec_go) busy_nxt = busy_nxt & ~le_mask(p_idx);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rec_go) state_nxt = ISSUE;
            ISSUE:   state_nxt = FLUSH;
            FLUSH:   state_nxt = rec_go ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= '0;
            cnt        <= '0;
            for (int i = 0; i < STACK_NUM; i++) fifo[i] <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_pc    <= '0;
            rec_q      <= 1'b0;
            cor_q      <= 1'b0;
            redir_q    <= 1'b0;
            mask_q     <= '0;
            squash_q   <= '0;
            pc_q       <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= busy_nxt;
            cnt        <= cnt_nxt;
            fifo       <= fifo_nxt;
            pend_valid <= rec_go ? 1'b0 : p_v;
            if (win_v) begin
                pend_idx <= win_idx;
                pend_pc  <= win_pc;
            end
            rec_q    <= rec_go;
            cor_q    <= pop;
            redir_q  <= rec_go;
            mask_q   <= rec_go ? (STACK_NUM'(1) << p_idx) :
                        pop    ? (STACK_NUM'(1) << head)  : '0;
            squash_q <= rec_go ? le_mask(p_idx) : '0;
            pc_q     <= rec_go ? p_pc : '0;
        end
    end
endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Directed bench for br_resolve_ctrl: allocation order, mispredict priority,
// correct ordering, late resolutions during ISSUE, and reset mid-recovery.
module tb_br_resolve_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    br_resolve_ctrl_if #(.STACK_NUM(4)) bus ();
    br_resolve_ctrl #(.STACK_NUM(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_res();
        bus.res_valid_0 = 0; bus.res_mask_0 = '0; bus.res_mispredict_0 = 0; bus.res_target_0 = '0;
        bus.res_valid_1 = 0; bus.res_mask_1 = '0; bus.res_mispredict_1 = 0; bus.res_target_1 = '0;
    endtask

    task automatic res(input int p, input logic [3:0] m, input logic mp, input logic [63:0] t);
        if (p == 0) begin
            bus.res_valid_0 = 1; bus.res_mask_0 = m; bus.res_mispredict_0 = mp; bus.res_target_0 = t;
        end else begin
            bus.res_valid_1 = 1; bus.res_mask_1 = m; bus.res_mispredict_1 = mp; bus.res_target_1 = t;
        end
    endtask

    task automatic do_reset();
        reset = 1; bus.br_dispatch_valid = 0; clear_res();
        tick(); tick();
        reset = 0;
    endtask

    task automatic alloc_n(input int n);
        bus.br_dispatch_valid = 1;
        repeat (n) tick();
        bus.br_dispatch_valid = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rr"}, bus.recovery_request, 0);
        check({tag, "_bc"}, bus.br_correct, 0);
        check({tag, "_rv"}, bus.redirect_valid, 0);
        check({tag, "_rm"}, bus.recovery_mask, 0);
        check({tag, "_sq"}, bus.squash_mask, 0);
        check({tag, "_pc"}, bus.redirect_pc, 0);
        check({tag, "_snap"}, bus.snapshot_enable, 0);
        check({tag, "_sa"}, bus.space_address, 0);
    endtask

    initial begin
        bus.br_dispatch_valid = 0;
        clear_res();
        do_reset();

        // Reset state
        check_idle_outputs("rst");
        check("rst_busy", dut.busy, 4'b0000);
        check("rst_stall", bus.br_dispatch_stall, 0);

        // Back-to-back allocation 3,2,1,0 then full
        bus.br_dispatch_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alloc_snap", bus.snapshot_enable, 1);
            check("alloc_addr", bus.space_address, 3 - i);
            check("alloc_stall", bus.br_dispatch_stall, 0);
            tick();
        end
        #1;
        check("full_stall", bus.br_dispatch_stall, 1);
        check("full_snap", bus.snapshot_enable, 0);
        check("full_busy", dut.busy, 4'b1111);
        bus.br_dispatch_valid = 0;

        // Two mispredicts, oldest (slot 2) wins
        do_reset();
        alloc_n(3);
        check("mp2_busy0", dut.busy, 4'b1110);
        res(0, 4'b0010, 1, 64'h200);
        res(1, 4'b0100, 1, 64'h100);
        tick();
        clear_res();
        check("mp2_rr", bus.recovery_request, 1);
        check("mp2_rv", bus.redirect_valid, 1);
        check("mp2_mask", bus.recovery_mask, 4'b0100);
        check("mp2_sq", bus.squash_mask, 4'b0111);
        check("mp2_pc", bus.redirect_pc, 64'h100);
        check("mp2_bc", bus.br_correct, 0);
        check("mp2_busy", dut.busy, 4'b1000);
        check("mp2_stall", bus.br_dispatch_stall, 1);
        tick();
        check("mp2_flush_rr", bus.recovery_request, 0);
        check("mp2_flush_stall", bus.br_dispatch_stall, 1);
        tick();
        check("mp2_idle_rr", bus.recovery_request, 0);
        check("mp2_idle_stall", bus.br_dispatch_stall, 0);

        // Two corrects in one cycle pop oldest-port-first on consecutive cycles
        bus.br_dispatch_valid = 1;
        #1;
        check("cor_alloc_addr", bus.space_address, 2);
        tick();
        bus.br_dispatch_valid = 0;
        check("cor_busy0", dut.busy, 4'b1100);
        res(0, 4'b1000, 0, 64'h0);
        res(1, 4'b0100, 0, 64'h0);
        tick();
        clear_res();
        check("cor1_bc", bus.br_correct, 1);
        check("cor1_mask", bus.recovery_mask, 4'b1000);
        check("cor1_rr", bus.recovery_request, 0);
        tick();
        check("cor2_bc", bus.br_correct, 1);
        check("cor2_mask", bus.recovery_mask, 4'b0100);
        tick();
        check("cor3_bc", bus.br_correct, 0);
        check("cor_busy", dut.busy, 4'b0000);

        // Correct on 3 plus mispredict on 1: recovery first, then correct
        do_reset();
        alloc_n(3);
        res(0, 4'b1000, 0, 64'h0);
        res(1, 4'b0010, 1, 64'h40);
        tick();
        clear_res();
        check("mix_rr", bus.recovery_request, 1);
        check("mix_mask", bus.recovery_mask, 4'b0010);
        check("mix_sq", bus.squash_mask, 4'b0011);
        check("mix_pc", bus.redirect_pc, 64'h40);
        check("mix_bc0", bus.br_correct, 0);
        check("mix_busy0", dut.busy, 4'b1100);
        tick();
        check("mix_bc", bus.br_correct, 1);
        check("mix_bmask", bus.recovery_mask, 4'b1000);
        check("mix_rr1", bus.recovery_request, 0);
        check("mix_busy1", dut.busy, 4'b0100);
        tick();
        check("mix_bc_end", bus.br_correct, 0);

        // Younger resolution during ISSUE is dropped
        do_reset();
        alloc_n(4);
        res(0, 4'b0100, 1, 64'h80);
        tick();
        check("late_rr", bus.recovery_request, 1);
        check("late_mask", bus.recovery_mask, 4'b0100);
        clear_res();
        res(0, 4'b0001, 1, 64'h999);
        tick();
        clear_res();
        check("late_flush_rr", bus.recovery_request, 0);
        tick();
        check("late_idle_rr", bus.recovery_request, 0);
        tick();
        check("late_idle_rr2", bus.recovery_request, 0);
        check("late_bc", bus.br_correct, 0);
        check("late_busy", dut.busy, 4'b1000);

        // Older mispredict during ISSUE is issued after FLUSH
        do_reset();
        alloc_n(4);
        res(0, 4'b0010, 1, 64'h10);
        tick();
        clear_res();
        check("old_rr", bus.recovery_request, 1);
        check("old_mask", bus.recovery_mask, 4'b0010);
        check("old_busy", dut.busy, 4'b1100);
        res(1, 4'b1000, 1, 64'h300);
        tick();
        clear_res();
        check("old_flush_rr", bus.recovery_request, 0);
        check("old_flush_stall", bus.br_dispatch_stall, 1);
        tick();
        check("old2_rr", bus.recovery_request, 1);
        check("old2_mask", bus.recovery_mask, 4'b1000);
        check("old2_sq", bus.squash_mask, 4'b1111);
        check("old2_pc", bus.redirect_pc, 64'h300);
        check("old2_busy", dut.busy, 4'b0000);
        tick();
        check("old2_end_rr", bus.recovery_request, 0);

        // Reset during ISSUE
        do_reset();
        alloc_n(3);
        res(0, 4'b0100, 1, 64'h55);
        tick();
        clear_res();
        check("rstiss_rr", bus.recovery_request, 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        check_idle_outputs("rstiss");
        check("rstiss_busy", dut.busy, 4'b0000);
        bus.br_dispatch_valid = 1;
        #1;
        check("rstiss_snap", bus.snapshot_enable, 1);
        check("rstiss_addr", bus.space_address, 3);
        tick();
        bus.br_dispatch_valid = 0;
        check("rstiss_busy1", dut.busy, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
